// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the race-game sequencer.
//   state_t   : sequencer state encoding
//   STATE_W   : width of the state register
//   winner_w(): index width for a count of items (never below 1 bit)
package game_ctrl_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_RESET      = 4'd0,
    S_START_DRAW = 4'd1,
    S_START_WAIT = 4'd2,
    S_START_REL  = 4'd3,
    S_LAYER      = 4'd4,
    S_CHECK      = 4'd5,
    S_IDLE       = 4'd6,
    S_MOVE       = 4'd7,
    S_WIN_DRAW   = 4'd8,
    S_WIN_WAIT   = 4'd9,
    S_WIN_REL    = 4'd10
  } state_t;

  function automatic int winner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Bus between the sequencer, the position datapath and the draw engines.
//   master : sequencer side (drives strobes, winner, draw_error)
//   slave  : datapath/engine side (drives frame tick, keys, done pulses)
interface game_sequencer_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_LAYERS  = 3
) ();
  import game_ctrl_pkg::*;

  localparam int WIN_W = winner_w(NUM_PLAYERS);

  logic                   Enable1Frame;
  logic                   start;
  logic [NUM_PLAYERS-1:0] move;
  logic [NUM_PLAYERS-1:0] win;
  logic                   screen_done;
  logic [NUM_LAYERS-1:0]  draw_done;

  logic                   reset_signals;
  logic                   draw_start_screen;
  logic                   draw_win_screen;
  logic [NUM_LAYERS-1:0]  draw_layer;
  logic [NUM_PLAYERS-1:0] move_car;
  logic                   plot;
  logic [WIN_W-1:0]       winner;
  logic                   draw_error;

  modport master (
    input  Enable1Frame, start, move, win, screen_done, draw_done,
    output reset_signals, draw_start_screen, draw_win_screen, draw_layer,
           move_car, plot, winner, draw_error
  );

  modport slave (
    output Enable1Frame, start, move, win, screen_done, draw_done,
    input  reset_signals, draw_start_screen, draw_win_screen, draw_layer,
           move_car, plot, winner, draw_error
  );

endinterface

// File: rtl/game_sequencer_draw_watchdog.sv
// Draw watchdog: counts cycles while en is high, restarts on clr or when
// disabled, and flags timeout on the DONE_TIMEOUT-th cycle of a draw.
//   Clock, Reset : clock, synchronous active-high reset
//   en           : currently in a draw state
//   clr          : draw state or layer index is changing this cycle
//   timeout      : force the current draw to advance
// DONE_TIMEOUT = 0 removes the counter and ties timeout low.
module draw_watchdog #(
  parameter int DONE_TIMEOUT = 65536
) (
  input  logic Clock,
  input  logic Reset,
  input  logic en,
  input  logic clr,
  output logic timeout
);

  generate
    if (DONE_TIMEOUT == 0) begin : g_off
      assign timeout = 1'b0;
    end else begin : g_on
      localparam int CW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
      localparam logic [CW-1:0] LIMIT = CW'(DONE_TIMEOUT - 1);

      logic [CW-1:0] cnt;

      always_ff @(posedge Clock) begin
        if (Reset || clr || !en) cnt <= '0;
        else                     cnt <= cnt + 1'b1;
      end

      // cnt is 0 on the first cycle of a draw, so this fires on cycle DONE_TIMEOUT
      assign timeout = en && (cnt == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/game_sequencer.sv
// Top-level race game sequencer: start screen, per-frame layer redraws,
// frame-gated multi-player moves, winner arbitration and the win screen.
//   Clock, Reset : clock, synchronous active-high reset
//   bus          : game_sequencer_if.master (keys, frame tick, engine
//                  handshakes in; strobes, winner, draw_error out)
module game_sequencer
  import game_ctrl_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int NUM_LAYERS      = 3,
  parameter int FRAMES_PER_MOVE = 1,
  parameter int DONE_TIMEOUT    = 65536
) (
  input  logic              Clock,
  input  logic              Reset,
  game_sequencer_if.master  bus
);

  localparam int WIN_W = winner_w(NUM_PLAYERS);
  localparam int IDX_W = winner_w(NUM_LAYERS);
  localparam int FRM_W = winner_w(FRAMES_PER_MOVE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);
  localparam logic [FRM_W-1:0] FRM_MAX  = FRM_W'(FRAMES_PER_MOVE - 1);

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       idx, idx_nxt;
  logic [FRM_W-1:0]       frm_cnt, frm_nxt;
  logic [WIN_W-1:0]       winner_q, win_lo;
  logic [NUM_PLAYERS-1:0] move_q;
  logic                   err_q;
  logic                   in_draw, done_now, adv, wd_clr, wd_timeout;

  assign in_draw = (state == S_START_DRAW) || (state == S_LAYER) || (state == S_WIN_DRAW);

  // Only the engine currently requested can finish the draw
  always_comb begin
    done_now = 1'b0;
    case (state)
      S_START_DRAW, S_WIN_DRAW: done_now = bus.screen_done;
      S_LAYER:                  done_now = bus.draw_done[idx];
      default:                  done_now = 1'b0;
    endcase
  end

  // A watchdog expiry advances the draw exactly like a done pulse
  assign adv    = done_now || wd_timeout;
  assign wd_clr = (state_nxt != state) || (idx_nxt != idx);

  draw_watchdog #(.DONE_TIMEOUT(DONE_TIMEOUT)) u_wd (
    .Clock   (Clock),
    .Reset   (Reset),
    .en      (in_draw),
    .clr     (wd_clr),
    .timeout (wd_timeout)
  );

  // Lowest-index finisher wins ties
  always_comb begin
    win_lo = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--)
      if (bus.win[i]) win_lo = WIN_W'(i);
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    frm_nxt   = frm_cnt;
    case (state)
      S_RESET:      state_nxt = S_START_DRAW;
      S_START_DRAW: if (adv) state_nxt = S_START_WAIT;
      S_START_WAIT: if (bus.start) state_nxt = S_START_REL;
      S_START_REL:  if (!bus.start) begin
                      state_nxt = S_LAYER;
                      idx_nxt   = '0;
                    end
      S_LAYER:      if (adv) begin
                      if (idx == LAST_IDX) begin
                        idx_nxt   = '0;
                        state_nxt = S_CHECK;
                      end else begin
                        idx_nxt = idx + 1'b1;
                      end
                    end
      S_CHECK:      if (|bus.win) begin
                      state_nxt = S_WIN_DRAW;
                    end else begin
                      state_nxt = S_IDLE;
                      frm_nxt   = '0;
                    end
      S_IDLE:       if (bus.Enable1Frame) begin
                      if ((frm_cnt == FRM_MAX) && |bus.move) state_nxt = S_MOVE;
                      if (frm_cnt != FRM_MAX) frm_nxt = frm_cnt + 1'b1;
                    end
      S_MOVE:       state_nxt = S_LAYER;
      S_WIN_DRAW:   if (adv) state_nxt = S_WIN_WAIT;
      S_WIN_WAIT:   if (bus.start) state_nxt = S_WIN_REL;
      S_WIN_REL:    if (!bus.start) state_nxt = S_RESET;
      default:      state_nxt = S_RESET;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= S_RESET;
      idx      <= '0;
      frm_cnt  <= '0;
      winner_q <= '0;
      err_q    <= 1'b0;
      move_q   <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      frm_cnt <= frm_nxt;
      if ((state == S_CHECK) && |bus.win) winner_q <= win_lo;
      else if (state_nxt == S_RESET)      winner_q <= '0;
      if (wd_timeout && !done_now) err_q <= 1'b1;
      // Freeze the request so move_car is stable for its single cycle
      if ((state == S_IDLE) && (state_nxt == S_MOVE)) move_q <= bus.move;
    end
  end

  always_comb begin
    bus.reset_signals     = 1'b0;
    bus.draw_start_screen = 1'b0;
    bus.draw_win_screen   = 1'b0;
    bus.draw_layer        = '0;
    bus.move_car          = '0;
    bus.plot              = 1'b0;
    case (state)
      S_RESET:      bus.reset_signals = 1'b1;
      S_START_DRAW: begin
                      bus.draw_start_screen = 1'b1;
                      bus.plot              = ~bus.screen_done;
                    end
      S_LAYER:      begin
                      bus.draw_layer = NUM_LAYERS'(1) << idx;
                      bus.plot       = ~bus.draw_done[idx];
                    end
      S_MOVE:       bus.move_car = move_q;
      S_WIN_DRAW:   begin
                      bus.draw_win_screen = 1'b1;
                      bus.plot            = ~bus.screen_done;
                    end
      default:      ;
    endcase
  end

  assign bus.winner     = winner_q;
  assign bus.draw_error = err_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: a scripted game walk computes the expected
// outputs for every cycle while driving randomized inputs; one negedge
// process compares all outputs, plus armed literal checks.
module tb_game_sequencer;
  import game_ctrl_pkg::*;

  localparam int NP = 2, NL = 3, FPM = 3, DT = 16;
  localparam int WW = winner_w(NP);
  localparam int L_RST = 0, L_LAYER = 1, L_MOVE = 2, L_WINNER = 3, L_ERR = 4;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  game_sequencer_if #(.NUM_PLAYERS(NP), .NUM_LAYERS(NL)) bus ();

  game_sequencer #(
    .NUM_PLAYERS(NP), .NUM_LAYERS(NL), .FRAMES_PER_MOVE(FPM), .DONE_TIMEOUT(DT)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks = 0, failures = 0;
  logic chk_en = 1'b0;

  logic          e_rst, e_sds, e_wds, e_plot, e_err;
  logic [NL-1:0] e_layer;
  logic [NP-1:0] e_move;
  logic [WW-1:0] e_winner;

  logic       lit_req = 1'b0;
  int         lit_sel = 0;
  logic [7:0] lit_want = '0;
  string      lit_name = "";

  logic          m_err = 1'b0;
  logic [WW-1:0] m_winner = '0;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (chk_en) begin
      cmp("reset_signals",     8'(bus.reset_signals),     8'(e_rst));
      cmp("draw_start_screen", 8'(bus.draw_start_screen), 8'(e_sds));
      cmp("draw_win_screen",   8'(bus.draw_win_screen),   8'(e_wds));
      cmp("draw_layer",        8'(bus.draw_layer),        8'(e_layer));
      cmp("move_car",          8'(bus.move_car),          8'(e_move));
      cmp("plot",              8'(bus.plot),              8'(e_plot));
      cmp("winner",            8'(bus.winner),            8'(e_winner));
      cmp("draw_error",        8'(bus.draw_error),        8'(e_err));
      if (lit_req) begin
        case (lit_sel)
          L_RST:    cmp(lit_name, 8'(bus.reset_signals), lit_want);
          L_LAYER:  cmp(lit_name, 8'(bus.draw_layer),    lit_want);
          L_MOVE:   cmp(lit_name, 8'(bus.move_car),      lit_want);
          L_WINNER: cmp(lit_name, 8'(bus.winner),        lit_want);
          default:  cmp(lit_name, 8'(bus.draw_error),    lit_want);
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
    lit_req = 1'b0;
  endtask

  // Literal expectation for the next scripted cycle
  task automatic arm(input int sel, input logic [7:0] v, input string nm);
    lit_req = 1'b1; lit_sel = sel; lit_want = v; lit_name = nm;
  endtask

  // Inputs the current state must ignore get random values
  task automatic noise();
    bus.Enable1Frame = ($urandom_range(0, 2) == 0);
    bus.start        = ($urandom_range(0, 1) == 1);
    bus.move         = NP'($urandom);
    bus.win          = NP'($urandom);
    bus.screen_done  = ($urandom_range(0, 1) == 1);
    bus.draw_done    = NL'($urandom);
  endtask

  task automatic exp0();
    e_rst = 1'b0; e_sds = 1'b0; e_wds = 1'b0; e_plot = 1'b0;
    e_layer = '0; e_move = '0; e_err = m_err; e_winner = m_winner;
  endtask

  task automatic reset_cycle();
    m_winner = '0;
    noise(); exp0(); e_rst = 1'b1; tick();
  endtask

  task automatic screen(input bit is_win, input int d);
    for (int i = 0; i < d; i++) begin
      noise(); bus.screen_done = 1'b0; exp0();
      if (is_win) e_wds = 1'b1; else e_sds = 1'b1;
      e_plot = 1'b1; tick();
    end
    noise(); bus.screen_done = 1'b1; exp0();
    if (is_win) e_wds = 1'b1; else e_sds = 1'b1;
    tick();
  endtask

  task automatic wait_start(input int pre, input int hold);
    for (int i = 0; i < pre; i++) begin
      noise(); bus.start = 1'b0; exp0(); tick();
    end
    for (int i = 0; i < hold; i++) begin
      noise(); bus.start = 1'b1; exp0(); tick();
    end
    noise(); bus.start = 1'b0; exp0(); tick();
  endtask

  task automatic draw_layers(input int tmo, input int rst, output bit was_reset);
    logic [NL-1:0] oh;
    int n;
    was_reset = 1'b0;
    for (int l = 0; l < NL; l++) begin
      oh = NL'(1) << l;
      if (l == rst) begin
        noise(); bus.draw_done = bus.draw_done & ~oh; exp0();
        e_layer = oh; e_plot = 1'b1; Reset = 1'b1; tick(); Reset = 1'b0;
        m_err = 1'b0; m_winner = '0; was_reset = 1'b1;
        return;
      end
      n = (l == tmo) ? DT : int'($urandom_range(0, 10));
      for (int i = 0; i < n; i++) begin
        noise(); bus.draw_done = bus.draw_done & ~oh; exp0();
        e_layer = oh; e_plot = 1'b1; tick();
      end
      if (l == tmo) begin
        m_err = 1'b1;
        arm(L_ERR, 8'd1, "draw_error_after_timeout");
      end else begin
        noise(); bus.draw_done = bus.draw_done | oh; exp0();
        e_layer = oh; tick();
      end
    end
  endtask

  task automatic check_cycle(input logic [NP-1:0] wv);
    bit found;
    noise(); bus.win = wv; exp0(); tick();
    found = 1'b0;
    for (int i = 0; i < NP; i++)
      if (wv[i] && !found) begin m_winner = WW'(i); found = 1'b1; end
  endtask

  // A move is due on a frame pulse once FPM pulses have been seen since the
  // redraw finished, provided some player is requesting one
  task automatic idle(input bit directed, input logic [NP-1:0] dmv);
    int pulses;
    logic [NP-1:0] cap;
    bit fire;
    pulses = 0; cap = '0;
    for (int k = 0; k < 200; k++) begin
      noise();
      if (directed) begin
        bus.Enable1Frame = (k % 2 == 1); bus.move = dmv;
      end else if (k > 60) begin
        bus.Enable1Frame = 1'b1; bus.move = NP'(1);
      end else if ($urandom_range(0, 3) == 0) begin
        bus.move = '0;
      end
      exp0();
      if (bus.Enable1Frame) pulses++;
      fire = bus.Enable1Frame && (pulses >= FPM) && (bus.move != '0);
      cap  = bus.move;
      tick();
      if (fire) break;
    end
    if (directed) arm(L_MOVE, 8'(dmv), "move_car_directed");
    noise(); exp0(); e_move = cap; tick();
  endtask

  task automatic win_flow();
    screen(1'b1, int'($urandom_range(0, 10)));
    wait_start(int'($urandom_range(0, 4)), int'($urandom_range(1, 4)));
    arm(L_RST, 8'd1, "reset_signals_after_win");
    reset_cycle();
    screen(1'b0, int'($urandom_range(0, 10)));
    wait_start(int'($urandom_range(0, 4)), int'($urandom_range(1, 4)));
  endtask

  task automatic pass(input int tmo, input int rst, input logic [NP-1:0] wv,
                      input bit directed, input logic [NP-1:0] dmv, input int win_lit);
    bit r;
    draw_layers(tmo, rst, r);
    if (r) begin
      arm(L_RST, 8'd1, "reset_signals_mid_layer");
      reset_cycle();
      screen(1'b0, 5);
      wait_start(1, 2);
      return;
    end
    check_cycle(wv);
    if (wv != '0) begin
      if (win_lit >= 0) arm(L_WINNER, 8'(win_lit), "winner_literal");
      win_flow();
    end else begin
      idle(directed, dmv);
    end
  endtask

  initial begin
    logic [NP-1:0] wv;
    bus.Enable1Frame = 1'b0; bus.start = 1'b0; bus.move = '0; bus.win = '0;
    bus.screen_done = 1'b0; bus.draw_done = '0;
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    chk_en = 1'b1;

    arm(L_RST, 8'd1, "reset_signals_after_reset");
    reset_cycle();
    screen(1'b0, 5);
    wait_start(2, 3);

    arm(L_LAYER, 8'h01, "first_layer_background");
    pass(-1, -1, 2'b00, 1'b1, 2'b01, -1);
    pass(-1, -1, 2'b00, 1'b1, 2'b11, -1);
    pass(-1, -1, 2'b11, 1'b0, 2'b00, 0);
    pass( 1, -1, 2'b00, 1'b0, 2'b00, -1);
    for (int p = 0; p < 14; p++) begin
      wv = ($urandom_range(0, 4) == 0) ? NP'($urandom_range(1, 3)) : '0;
      pass(-1, -1, wv, 1'b0, 2'b00, -1);
    end
    pass(-1,  1, 2'b00, 1'b0, 2'b00, -1);
    pass(-1, -1, 2'b10, 1'b0, 2'b00, 1);
    pass(-1, -1, 2'b00, 1'b0, 2'b00, -1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
